// File: rtl/data_types_pkg.sv
// data_types_pkg: shared UART TX types, frame config struct and length clamp helper
package data_types_pkg;
  localparam int UART_MAX_WORD = 9;
  localparam int UART_DIV_W = 16;
  typedef enum logic [1:0] {NONE = 2'd0, EVEN = 2'd1, ODD = 2'd2} uart_parity_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  typedef struct packed {
    logic [UART_DIV_W-1:0] br_div;
    logic [3:0] len;
    uart_parity_t parity;
    logic stop;
    logic en;
  } uart_tx_cfg_t;
  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    return l < 4'd5 ? 4'd5 : (l > 4'd9 ? 4'd9 : l);
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through synchronous FIFO; a push while full is refused even if popping
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rd_data = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: FIFO-buffered UART transmitter, 5-9 data bits, 1/2 stop bits
// parity support compiled in only when UART_TX_PARITY_EN is defined
module uart_tx_buf
  import data_types_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  uart_tx_cfg_t                    cfg,
  input  logic [8:0]                      wr_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  output logic                            tx,
  output logic                            idle,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  uart_tx_state_t state, state_n;
  uart_tx_cfg_t f_cfg;
  logic [UART_MAX_WORD-1:0] sh, head;
  logic [DIV_W-1:0] cnt, br_m1;
  logic [3:0] bit_cnt, f_len;
  logic full, empty, pop, go, bit_end, last_data, last_stop;
  uart_sync_fifo #(.WIDTH(UART_MAX_WORD), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(wr_valid), .pop(pop), .wr_data(wr_data),
    .rd_data(head), .full(full), .empty(empty), .count(fifo_count)
  );
  assign wr_ready = !full;
  assign idle = state == IDLE;
  assign go = cfg.en && !empty;
  assign f_len = clamp_len(f_cfg.len);
  assign br_m1 = f_cfg.br_div == '0 ? '0 : DIV_W'(f_cfg.br_div - 1'b1);
  assign bit_end = cnt == br_m1;
  assign last_data = bit_cnt == f_len - 4'd1;
  assign last_stop = bit_cnt == {3'b0, f_cfg.stop};
`ifdef UART_TX_PARITY_EN
  logic par_bit, par_en;
  assign par_en = f_cfg.parity == EVEN || f_cfg.parity == ODD;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = go;
        state_n = go ? START : IDLE;
      end
      START: state_n = bit_end ? DATA : START;
`ifdef UART_TX_PARITY_EN
      DATA: state_n = bit_end && last_data ? (par_en ? PARITY : STOP) : DATA;
      PARITY: state_n = bit_end ? STOP : PARITY;
`else
      DATA: state_n = bit_end && last_data ? STOP : DATA;
`endif
      STOP: if (bit_end && last_stop) begin
        pop = go;
        state_n = go ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    tx = 1'b1;
    if (state == START) tx = 1'b0;
    if (state == DATA) tx = sh[0];
`ifdef UART_TX_PARITY_EN
    if (state == PARITY) tx = par_bit;
`endif
  end
  // a pop always starts a fresh frame, including the back-to-back case out of STOP
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      bit_cnt <= '0;
    end else if (pop) begin
      f_cfg <= cfg;
      sh <= head;
      cnt <= '0;
      bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit <= ^(head & (9'h1ff >> (4'd9 - clamp_len(cfg.len)))) ^ (cfg.parity == ODD);
`endif
    end else if (state != IDLE) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
      if (bit_end) begin
        bit_cnt <= state_n == state ? bit_cnt + 4'd1 : 4'd0;
        if (state == DATA) sh <= sh >> 1;
      end
    end
endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: table-driven, directed and random checks against a bit-stream model
module tb_uart_tx_buf;
  import data_types_pkg::*;
`ifdef UART_TX_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  logic clk = 0, rst = 1, wr_valid = 0, wr_ready, tx, idle;
  logic [8:0] wr_data = '0;
  logic [3:0] fifo_count;
  uart_tx_cfg_t cfg;
  int checks = 0, errors = 0;
  bit exp_q[$];
  typedef struct {
    logic [8:0] d;
    logic [3:0] len;
    logic [1:0] par;
    logic stop;
    logic [15:0] br;
    int clocks;
  } vec_t;
  vec_t tbl[7];
  uart_tx_buf #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .cfg(cfg), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .tx(tx), .idle(idle), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic write(input logic [8:0] d);
    wr_data = d;
    wr_valid = 1;
    step();
    wr_valid = 0;
  endtask
  // expected line level per clock, built from the frame rules
  task automatic add_frame(input logic [8:0] w, input uart_tx_cfg_t c);
    int l, b;
    bit pe, p;
    bit bits[$];
    l = c.len < 5 ? 5 : (c.len > 9 ? 9 : int'(c.len));
    b = c.br_div == 0 ? 1 : int'(c.br_div);
    pe = 0;
`ifdef UART_TX_PARITY_EN
    pe = c.parity == EVEN || c.parity == ODD;
`endif
    p = c.parity == ODD;
    bits.push_back(0);
    for (int i = 0; i < l; i++) begin
      bits.push_back(w[i]);
      p ^= w[i];
    end
    if (pe) bits.push_back(p);
    bits.push_back(1);
    if (c.stop) bits.push_back(1);
    foreach (bits[i]) for (int k = 0; k < b; k++) exp_q.push_back(bits[i]);
  endtask
  task automatic run_frame(input string n, input int exp_clk);
    int k, bad;
    k = 0;
    bad = 0;
    while (!idle && k < 5000) begin
      if (k >= exp_q.size() || tx !== exp_q[k]) bad++;
      step();
      k++;
    end
    chk({n, " clocks"}, k, exp_clk);
    chk({n, " bad samples"}, bad, 0);
    chk({n, " tx after"}, int'(tx), 1);
    exp_q.delete();
  endtask
  initial begin
    logic [8:0] w;
    uart_tx_cfg_t c2;
    int n, bad;
    tbl[0] = '{9'h08E, 4'd8, 2'd0, 1'b0, 16'd8, 80};
    tbl[1] = '{9'h081, 4'd8, 2'd1, 1'b0, 16'd8, 8 * (10 + PE)};
    tbl[2] = '{9'h081, 4'd8, 2'd2, 1'b0, 16'd8, 8 * (10 + PE)};
    tbl[3] = '{9'h1FE, 4'd9, 2'd0, 1'b1, 16'd8, 96};
    tbl[4] = '{9'h015, 4'd3, 2'd0, 1'b0, 16'd0, 7};
    tbl[5] = '{9'h1FF, 4'd15, 2'd1, 1'b0, 16'd2, 2 * (11 + PE)};
    tbl[6] = '{9'h0AA, 4'd6, 2'd3, 1'b1, 16'd3, 27};
    cfg = '0;
    step();
    step();
    rst = 0;
    chk("reset tx", int'(tx), 1);
    chk("reset idle", int'(idle), 1);
    chk("reset wr_ready", int'(wr_ready), 1);
    chk("reset count", int'(fifo_count), 0);
    foreach (tbl[i]) begin
      cfg.br_div = tbl[i].br;
      cfg.len = tbl[i].len;
      cfg.parity = uart_parity_t'(tbl[i].par);
      cfg.stop = tbl[i].stop;
      cfg.en = 1;
      add_frame(tbl[i].d, cfg);
      write(tbl[i].d);
      chk($sformatf("row%0d count after write", i), int'(fifo_count), 1);
      chk($sformatf("row%0d idle before pop", i), int'(idle), 1);
      step();
      chk($sformatf("row%0d start bit", i), int'(tx), 0);
      run_frame($sformatf("row%0d", i), tbl[i].clocks);
    end
    cfg = '0;
    cfg.br_div = 3;
    cfg.len = 8;
    cfg.parity = EVEN;
    for (int i = 0; i < 9; i++) begin
      w = 9'(i * 37 + 5);
      if (i < 8) add_frame(w, cfg);
      write(w);
    end
    chk("burst count", int'(fifo_count), 8);
    chk("burst wr_ready", int'(wr_ready), 0);
    cfg.en = 1;
    step();
    run_frame("burst", 8 * 3 * (10 + PE));
    chk("burst drained", int'(fifo_count), 0);
    cfg = '0;
    cfg.br_div = 4;
    cfg.len = 8;
    add_frame(9'h0C3, cfg);
    c2 = cfg;
    c2.len = 5;
    add_frame(9'h05A, c2);
    write(9'h0C3);
    write(9'h05A);
    cfg.en = 1;
    step();
    cfg.len = 5;
    run_frame("len change", 4 * 10 + 4 * 7);
    cfg.en = 1;
    cfg.len = 8;
    cfg.br_div = 8;
    write(9'h0F0);
    write(9'h00F);
    write(9'h133);
    repeat (20) step();
    chk("pre-reset busy", int'(idle), 0);
    rst = 1;
    step();
    chk("mid reset tx", int'(tx), 1);
    chk("mid reset count", int'(fifo_count), 0);
    chk("mid reset idle", int'(idle), 1);
    rst = 0;
    bad = 0;
    repeat (300) begin
      step();
      if (tx !== 1'b1 || idle !== 1'b1) bad++;
    end
    chk("post reset quiet", bad, 0);
    for (int r = 0; r < 8; r++) begin
      cfg.en = 0;
      cfg.br_div = 16'($urandom_range(0, 3));
      cfg.len = 4'($urandom_range(0, 15));
      cfg.parity = uart_parity_t'($urandom_range(0, 3));
      cfg.stop = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        w = 9'($urandom);
        add_frame(w, cfg);
        write(w);
      end
      cfg.en = 1;
      step();
      run_frame($sformatf("rand%0d", r), exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Parametrised successor to the team's single-word UART transmitter. Accepts data words through a valid/ready write port into an internal FIFO. Serialises them back-to-back onto `tx` with a runtime-selectable frame: 5–9 data bits, optional even/odd parity, and 1 or 2 stop bits. Sits between the register/bus front end and the `tx` pad, clocked from the same baud reference clock as the existing transmitter.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: number of FIFO entries; must be a power of 2 and ≥ 2.
- `DIV_W`, default 16: width of the baud divider field.

Ports:
- `clk`  in  1  system clock; one clock for the whole block.
- `rst`  in  1  reset; synchronous, active-high.
- `cfg`  in  `uart_tx_cfg_t`  frame config with fields `br_div[DIV_W]`, `len[3:0]`, `parity`, `stop`, `en`.
- `wr_data`  in  9  word to send; LSB first; only `len` LSBs are used.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  FIFO not full.
- `tx`  out  1  serial line; idle-high.
- `idle`  out  1  FSM in IDLE.
- `fifo_count`  out  `$clog2(FIFO_DEPTH+1)`  number of occupied entries.

## Operation
- Write: a word is accepted when `wr_valid && wr_ready` on a rising edge. A write while full is dropped, and `wr_ready` stays low.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE→START: taken when `cfg.en` is high and the FIFO is not empty. On that edge:
  - pop one word;
  - latch the whole `cfg` into a frame register.
- Config changes mid-frame do not affect the frame in flight.
- Each bit lasts `br_div` clocks. `br_div` = 0 is treated as 1.
- `len` mapping: values 5–9 are legal. A value below 5 is treated as 5; a value above 9 is treated as 9.
- Bit order: START (0) → DATA bits LSB first → PARITY (only if parity ≠ NONE) → STOP (1, one bit if `stop`=0, two bits if `stop`=1).
- Parity:
  - EVEN: the parity bit is the XOR of the sent data bits.
  - ODD: the inverted XOR.
  - The encoding value 3 is treated as NONE.
- Back-to-back: on the last clock of STOP, if `cfg.en` is high and the FIFO is not empty, the FSM pops, latches config, and goes straight to START with no idle bit. Otherwise it goes to IDLE.
- `cfg.en` deasserted mid-frame: the current frame completes, then the FSM goes to IDLE. FIFO contents are retained.
- Simultaneous write and pop:
  - count unchanged;
  - when the FIFO is full, the write is refused even if a pop happens in the same cycle.

## Timing
- Reset values: `tx`=1, `idle`=1, `wr_ready`=1, `fifo_count`=0. The FSM is in IDLE, the FIFO is flushed, and the counters are 0.
- Reset mid-frame: `tx`=1 from the edge on which `rst` is sampled high, and the partial frame is aborted.
- Latency: a word written into an empty FIFO while IDLE drives `tx` low 2 clocks after the write edge:
  - edge 1: write;
  - edge 2: pop, and enter START.
- Frame length in clocks: `br_div × (1 + len + P + S)`, where P = 1 if parity is enabled and S = 1 or 2.
- `idle` falls on the same edge that enters START and rises on the edge that leaves STOP to IDLE.
- `fifo_count` and `wr_ready` update on the edge of the write or pop, so there is no combinational path from `wr_valid` to `wr_ready`.

## Configuration
- `UART_TX_PARITY_EN` defined: parity logic and the PARITY state are compiled in, and `cfg.parity` is honoured.
- Not defined: the PARITY state and XOR logic are absent, `cfg.parity` is ignored, and every frame is sent as NONE.

## Structure
- `data_types_pkg` holds the shared definitions:
  - `uart_tx_cfg_t` (packed struct);
  - `uart_parity_t` enum (NONE=0, EVEN=1, ODD=2);
  - `uart_tx_state_t` enum;
  - constant `UART_MAX_WORD` = 9.
- Sub-module `uart_sync_fifo`, parametrised by width and depth, is reused by the future RX path. It provides:
  - `push`/`pop`, `full`/`empty` and `count`;
  - no read latency: the head word is visible combinationally.
- The top level contains:
  - the FSM;
  - the baud counter;
  - the bit counter;
  - the frame shift register and frame config register.

## Test plan
- Reset, then write 0x8E with `br_div`=8, `len`=8, parity NONE, 1 stop:
  - `tx` holds 0 for 8 clocks, then bits 0,1,1,1,0,0,0,1 for 8 clocks each, then 1;
  - 80-clock frame, `idle` back to 1 afterwards.
- Parity EVEN, `len`=8, data 0x81: parity bit is 0. Parity ODD, same data: parity bit is 1. With `UART_TX_PARITY_EN` undefined: no parity bit, 80-clock frame.
- `len`=9, `stop`=1, data 0x1FE:
  - 9 data bits 0,1,1,1,1,1,1,1,1;
  - two stop bits;
  - 12×8 = 96 clocks.
- Burst FIFO_DEPTH+1 writes while `cfg.en`=0:
  - the first 8 are accepted, then `wr_ready`=0 and the 9th is dropped, with `fifo_count`=8;
  - set `en`=1: 8 frames go out back-to-back with no high gap between stop and start.
- Change `cfg.len` from 8 to 5 mid-frame: the current frame stays 8-bit and the next frame is 5-bit (7 bits × `br_div`).
- Assert `rst` for 1 clock mid-DATA: on that edge `tx`=1, `fifo_count`=0, `idle`=1, and no further frames are sent.
